// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller arbitrating IFetch and LSBuffer onto one 8-bit RAM port.
// Define MEM_IO_STALL_EN to throttle IO stores on io_buffer_full plus an IO_GAP spacing.
module mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IO_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  jump_flag,
  input  logic                  if_enable,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_success,
  output logic [31:0]           if_data,
  input  logic                  lsb_enable,
  input  logic [2:0]            lsb_op_size,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [31:0]           lsb_wdata,
  input  logic                  lsb_wr_tag,
  output logic                  lsb_success,
  output logic [31:0]           lsb_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  localparam logic Store = 1'b1;

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  len_q;
  logic        is_fetch_q;
  logic [31:0] buf_q;
  logic        mem_wr_q;
  logic        stall_q;
  logic [7:0]  din_hold_q;

  logic [7:0]  din;
  logic [1:0]  cap_idx;
  logic [1:0]  wr_idx;
  logic [31:0] word_next;
  logic [7:0]  next_dout;
  logic        idle_ok;
  logic        start_lsb;
  logic        start_if;
  logic        io_block;

  assign mem_wr = mem_wr_q & rdy;

  // The RAM keeps responding during a freeze, so the byte that arrived on the first stalled
  // cycle is parked and used on resume instead of the stale mem_din.
  assign din     = stall_q ? din_hold_q : mem_din;
  assign cap_idx = cnt_q[1:0] - 2'd1;
  assign wr_idx  = cnt_q[1:0] + 2'd1;

  always_comb begin
    word_next = buf_q;
    word_next[{cap_idx, 3'b000} +: 8] = din;
  end

  assign next_dout = lsb_wdata[{wr_idx, 3'b000} +: 8];

  assign idle_ok   = (state_q == StIdle) && !jump_flag && !if_success && !lsb_success;
  assign start_lsb = idle_ok && lsb_enable && !io_block;
  assign start_if  = idle_ok && !start_lsb && if_enable;

`ifdef MEM_IO_STALL_EN
  localparam logic [7:0] GapInit = (IO_GAP == 0) ? 8'd0 : 8'(IO_GAP - 1);

  logic [7:0] io_gap_q;
  logic       is_io;

  assign is_io    = (lsb_wr_tag == Store) && (lsb_addr[17:16] == 2'b11);
  assign io_block = is_io && (io_buffer_full || (io_gap_q != 8'd0));

  // Counts the blank cycles owed after the final byte of an IO store.
  always_ff @(posedge clk) begin
    if (!rst) begin
      io_gap_q <= 8'd0;
    end else if (rdy) begin
      if ((state_q == StWrite) && ((cnt_q + 3'd1) == len_q) && is_io) begin
        io_gap_q <= GapInit;
      end else if (io_gap_q != 8'd0) begin
        io_gap_q <= io_gap_q - 8'd1;
      end
    end
  end
`else
  logic unused_io;
  assign unused_io = io_buffer_full | (IO_GAP == 0);
  assign io_block  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      is_fetch_q  <= 1'b0;
      buf_q       <= 32'd0;
      mem_wr_q    <= 1'b0;
      stall_q     <= 1'b0;
      din_hold_q  <= 8'd0;
      mem_a       <= '0;
      mem_dout    <= 8'd0;
      if_success  <= 1'b0;
      if_data     <= 32'd0;
      lsb_success <= 1'b0;
      lsb_rdata   <= 32'd0;
    end else begin
      stall_q <= !rdy;
      if (!rdy && !stall_q) begin
        din_hold_q <= mem_din;
      end
      if (rdy) begin
        if_success  <= 1'b0;
        lsb_success <= 1'b0;
        unique case (state_q)
          StIdle: begin
            mem_wr_q <= 1'b0;
            cnt_q    <= 3'd0;
            if (start_lsb) begin
              mem_a      <= lsb_addr;
              len_q      <= lsb_op_size;
              is_fetch_q <= 1'b0;
              buf_q      <= 32'd0;
              if (lsb_wr_tag == Store) begin
                state_q  <= StWrite;
                mem_wr_q <= 1'b1;
                mem_dout <= lsb_wdata[7:0];
              end else begin
                state_q <= StRead;
              end
            end else if (start_if) begin
              mem_a      <= if_addr;
              len_q      <= 3'd4;
              is_fetch_q <= 1'b1;
              buf_q      <= 32'd0;
              state_q    <= StRead;
            end
          end
          StRead: begin
            if (jump_flag) begin
              state_q <= StIdle;
            end else begin
              if (cnt_q != 3'd0) begin
                buf_q <= word_next;
              end
              if (cnt_q == len_q) begin
                state_q <= StIdle;
                if (is_fetch_q) begin
                  if_success <= 1'b1;
                  if_data    <= word_next;
                end else begin
                  lsb_success <= 1'b1;
                  lsb_rdata   <= word_next;
                end
              end else begin
                cnt_q <= cnt_q + 3'd1;
                if ((cnt_q + 3'd1) < len_q) begin
                  mem_a <= mem_a + ADDR_WIDTH'(1);
                end
              end
            end
          end
          StWrite: begin
            // Stores are committed, so jump_flag is deliberately ignored here.
            if ((cnt_q + 3'd1) == len_q) begin
              mem_wr_q    <= 1'b0;
              lsb_success <= 1'b1;
              state_q     <= StIdle;
            end else begin
              cnt_q    <= cnt_q + 3'd1;
              mem_a    <= mem_a + ADDR_WIDTH'(1);
              mem_dout <= next_dout;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus queues expected responses, a monitor checks them.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        jump_flag = 1'b0;
  logic        if_enable = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_success;
  logic [31:0] if_data;
  logic        lsb_enable = 1'b0;
  logic [2:0]  lsb_op_size = 3'd0;
  logic [31:0] lsb_addr = 32'd0;
  logic [31:0] lsb_wdata = 32'd0;
  logic        lsb_wr_tag = 1'b0;
  logic        lsb_success;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  mem_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .jump_flag     (jump_flag),
    .if_enable     (if_enable),
    .if_addr       (if_addr),
    .if_success    (if_success),
    .if_data       (if_data),
    .lsb_enable    (lsb_enable),
    .lsb_op_size   (lsb_op_size),
    .lsb_addr      (lsb_addr),
    .lsb_wdata     (lsb_wdata),
    .lsb_wr_tag    (lsb_wr_tag),
    .lsb_success   (lsb_success),
    .lsb_rdata     (lsb_rdata),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .mem_a         (mem_a),
    .mem_wr        (mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int wr_cnt = 0;
  int n_tests = 0;
  int n_fail = 0;

  // Byte RAM model: registered read, one cycle after mem_a.
  logic [7:0]  ram [0:262143];
  logic        pl_en = 1'b0;
  logic [17:0] pl_addr = 18'd0;
  logic [7:0]  pl_data = 8'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_din <= ram[mem_a[17:0]];
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_wr) begin
      ram[mem_a[17:0]] <= mem_dout;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    bit          kind;      // 0 fetch, 1 lsb
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input bit kind, input bit chk_data, input logic [31:0] data, input int c);
    exp_t e;
    e.kind = kind;
    e.chk_data = chk_data;
    e.data = data;
    e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic check_resp(input bit kind, input logic [31:0] data);
    exp_t e;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_resp: got kind %0d data %h at cycle %0d, required none",
               kind, data, cyc);
    end else begin
      e = sbq.pop_front();
      chk("resp_kind", 32'(kind), 32'(e.kind));
      if (e.chk_data) chk("resp_data", data, e.data);
      chk("resp_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (if_success) check_resp(1'b0, if_data);
      if (lsb_success) check_resp(1'b1, lsb_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic wait_success(input bit kind);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((kind ? lsb_success : if_success) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: kind %0d success never seen, required within 40 cycles", kind);
    end
  endtask

  task automatic lsb_req(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                         input logic [31:0] wd);
    lsb_addr = a;
    lsb_op_size = sz;
    lsb_wr_tag = wr;
    lsb_wdata = wd;
    lsb_enable = 1'b1;
  endtask

  int c;
  int wr_before;

  initial begin
    poke(18'h00100, 8'h13); poke(18'h00101, 8'h00); poke(18'h00102, 8'h00);
    poke(18'h00103, 8'h00);
    poke(18'h00104, 8'h93); poke(18'h00105, 8'h00); poke(18'h00106, 8'h10);
    poke(18'h00107, 8'h00);
    poke(18'h00200, 8'h78); poke(18'h00201, 8'h56); poke(18'h00202, 8'h34);
    poke(18'h00203, 8'h12);
    poke(18'h01001, 8'h55); poke(18'h00300, 8'hAB);
    poke(18'h00500, 8'h01); poke(18'h00501, 8'h02); poke(18'h00502, 8'h03);
    poke(18'h00503, 8'h04);
    poke(18'h3FFFE, 8'hAA); poke(18'h3FFFF, 8'hBB); poke(18'h00000, 8'hCC);
    poke(18'h00001, 8'hDD);

    // Reset values
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_if_success", 32'(if_success), 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_lsb_success", 32'(lsb_success), 32'd0);
    chk("rst_lsb_rdata", lsb_rdata, 32'd0);
    rst = 1'b1;
    tick(); tick();

    // 1: fetch at 0x100
    c = cyc;
    if_addr = 32'h100; if_enable = 1'b1;
    push(1'b0, 1'b1, 32'h00000013, c + 6);
    tick(); chk("t1_a0", mem_a, 32'h100);
    tick(); chk("t1_a1", mem_a, 32'h101);
    tick(); chk("t1_a2", mem_a, 32'h102);
    tick(); chk("t1_a3", mem_a, 32'h103);
    wait_success(1'b0);
    if_enable = 1'b0;
    tick(); tick();

    // 2: LW and fetch together, LSB first
    c = cyc;
    lsb_req(32'h200, 3'b100, 1'b0, 32'd0);
    if_addr = 32'h104; if_enable = 1'b1;
    push(1'b1, 1'b1, 32'h12345678, c + 6);
    push(1'b0, 1'b1, 32'h00100093, c + 13);
    tick(); chk("t2_a0", mem_a, 32'h200);
    wait_success(1'b1);
    lsb_enable = 1'b0;
    wait_success(1'b0);
    if_enable = 1'b0;
    tick(); tick();

    // 3: SH at 0x0FFF
    c = cyc;
    lsb_req(32'h0FFF, 3'b010, 1'b1, 32'hDEADBEEF);
    push(1'b1, 1'b0, 32'd0, c + 3);
    tick();
    chk("t3_wr0", 32'(mem_wr), 32'd1);
    chk("t3_a0", mem_a, 32'h0FFF);
    chk("t3_d0", 32'(mem_dout), 32'hEF);
    tick();
    chk("t3_wr1", 32'(mem_wr), 32'd1);
    chk("t3_a1", mem_a, 32'h1000);
    chk("t3_d1", 32'(mem_dout), 32'hBE);
    tick();
    chk("t3_wr2", 32'(mem_wr), 32'd0);
    wait_success(1'b1);
    lsb_enable = 1'b0;
    tick();
    chk("t3_ram0", 32'(ram[18'h00FFF]), 32'hEF);
    chk("t3_ram1", 32'(ram[18'h01000]), 32'hBE);
    chk("t3_ram2", 32'(ram[18'h01001]), 32'h55);
    tick();

    // 4: LB aborted by jump_flag, then a normal fetch
    lsb_req(32'h300, 3'b001, 1'b0, 32'd0);
    tick(); tick();
    jump_flag = 1'b1; lsb_enable = 1'b0;
    tick();
    jump_flag = 1'b0;
    chk("t4_no_success", 32'(lsb_success), 32'd0);
    tick(); tick();
    c = cyc;
    if_addr = 32'h104; if_enable = 1'b1;
    push(1'b0, 1'b1, 32'h00100093, c + 6);
    wait_success(1'b0);
    if_enable = 1'b0;
    tick(); tick();

    // 5: SW survives jump_flag
    wr_before = wr_cnt;
    c = cyc;
    lsb_req(32'h400, 3'b100, 1'b1, 32'h11223344);
    push(1'b1, 1'b0, 32'd0, c + 5);
    tick(); tick();
    jump_flag = 1'b1;
    tick();
    jump_flag = 1'b0;
    wait_success(1'b1);
    lsb_enable = 1'b0;
    tick();
    chk("t5_ram", {ram[18'h403], ram[18'h402], ram[18'h401], ram[18'h400]}, 32'h11223344);
    chk("t5_wr_count", 32'(wr_cnt - wr_before), 32'd4);
    tick();

    // 6: IO store against a full UART buffer
    c = cyc;
    io_buffer_full = 1'b1;
    lsb_req(32'h30000, 3'b001, 1'b1, 32'h000000A5);
`ifdef MEM_IO_STALL_EN
    push(1'b1, 1'b0, 32'd0, c + 7);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t6_stall_wr", 32'(mem_wr), 32'd0);
    end
    io_buffer_full = 1'b0;
    tick();
`else
    push(1'b1, 1'b0, 32'd0, c + 2);
    tick();
    io_buffer_full = 1'b0;
`endif
    chk("t6_wr", 32'(mem_wr), 32'd1);
    chk("t6_a", mem_a, 32'h30000);
    wait_success(1'b1);
    lsb_enable = 1'b0;
    tick();
    chk("t6_ram", 32'(ram[18'h30000]), 32'hA5);
    tick();

    // 7: rdy low for 3 cycles mid-read
    c = cyc;
    if_addr = 32'h500; if_enable = 1'b1;
    push(1'b0, 1'b1, 32'h04030201, c + 9);
    tick(); tick(); tick();
    rdy = 1'b0;
    tick(); tick();
    chk("t7_a_held", mem_a, 32'h502);
    chk("t7_wr_frozen", 32'(mem_wr), 32'd0);
    tick();
    rdy = 1'b1;
    wait_success(1'b0);
    if_enable = 1'b0;
    tick(); tick();

    // 8: fetch address wraps past 2^32
    c = cyc;
    if_addr = 32'hFFFF_FFFE; if_enable = 1'b1;
    push(1'b0, 1'b1, 32'hDDCCBBAA, c + 6);
    tick(); chk("t8_a0", mem_a, 32'hFFFF_FFFE);
    tick(); tick(); chk("t8_a2", mem_a, 32'h0);
    wait_success(1'b0);
    if_enable = 1'b0;
    tick(); tick(); tick();

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
